// File: rtl/wb_buffer.sv
// Single-entry write-back buffer: captures one dirty victim line and writes it to memory as an
// address phase, BEATS data beats and a write response, exposing a hazard compare meanwhile.
module wb_buffer #(
  parameter int unsigned TAG_WIDTH    = 24,
  parameter int unsigned INDEX_WIDTH  = 3,
  parameter int unsigned OFFSET_WIDTH = 5,
  parameter int unsigned LINE_WIDTH   = 256,
  parameter int unsigned BEAT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic [LINE_WIDTH-1:0]  in_data,
  output logic                   mem_awvalid,
  input  logic                   mem_awready,
  output logic [31:0]            mem_awaddr,
  output logic [7:0]             mem_awlen,
  output logic                   mem_wvalid,
  input  logic                   mem_wready,
  output logic [BEAT_WIDTH-1:0]  mem_wdata,
  output logic                   mem_wlast,
  input  logic                   mem_bvalid,
  output logic                   mem_bready,
  input  logic [TAG_WIDTH-1:0]   chk_tag,
  input  logic [INDEX_WIDTH-1:0] chk_index,
  output logic                   chk_hit,
  output logic                   busy
);

  localparam int unsigned Beats = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   accept;
  logic                   last_beat;
  logic [BEAT_WIDTH-1:0]  beat_sel;

  // Gating with rst keeps a capture from being signalled while reset is held.
  assign in_ready  = (state_q == StIdle) && rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CntW'(Beats - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= '0;
      index_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        tag_q   <= in_tag;
        index_q <= in_index;
        line_q  <= in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAw;
          cnt_d   = '0;
        end
      end
      StAw: begin
        if (mem_awready) state_d = StW;
      end
      StW: begin
        if (mem_wready) begin
          // Counter wraps to 0 on the final beat; it is reloaded on the next capture anyway.
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) state_d = StB;
        end
      end
      StB: begin
        if (mem_bvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    beat_sel = '0;
    for (int unsigned i = 0; i < Beats; i++) begin
      if (cnt_q == CntW'(i)) beat_sel = line_q[i*BEAT_WIDTH +: BEAT_WIDTH];
    end
  end

  assign busy        = (state_q != StIdle);
  assign mem_awvalid = (state_q == StAw);
  assign mem_awaddr  = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign mem_awlen   = (state_q == StAw) ? 8'(Beats - 1) : 8'd0;
  assign mem_wvalid  = (state_q == StW);
  assign mem_wdata   = beat_sel;
  assign mem_wlast   = (state_q == StW) && last_beat;
  assign mem_bready  = (state_q == StB);
  assign chk_hit     = busy && (chk_tag == tag_q) && (chk_index == index_q);

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: burst ordering, backpressure, occupancy, hazard compare and
// asynchronous reset, each scenario checking its own expected values.
module tb_wb_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [23:0]  in_tag = '0;
  logic [2:0]   in_index = '0;
  logic [255:0] in_data = '0;
  logic         mem_awvalid;
  logic         mem_awready = 1'b0;
  logic [31:0]  mem_awaddr;
  logic [7:0]   mem_awlen;
  logic         mem_wvalid;
  logic         mem_wready = 1'b0;
  logic [31:0]  mem_wdata;
  logic         mem_wlast;
  logic         mem_bvalid = 1'b0;
  logic         mem_bready;
  logic [23:0]  chk_tag = '0;
  logic [2:0]   chk_index = '0;
  logic         chk_hit;
  logic         busy;

  int tests = 0;
  int fails = 0;

  wb_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tag      (in_tag),
    .in_index    (in_index),
    .in_data     (in_data),
    .mem_awvalid (mem_awvalid),
    .mem_awready (mem_awready),
    .mem_awaddr  (mem_awaddr),
    .mem_awlen   (mem_awlen),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_wdata   (mem_wdata),
    .mem_wlast   (mem_wlast),
    .mem_bvalid  (mem_bvalid),
    .mem_bready  (mem_bready),
    .chk_tag     (chk_tag),
    .chk_index   (chk_index),
    .chk_hit     (chk_hit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Offer a line at a negedge while idle; returns one negedge after the accepting edge.
  task automatic offer(input logic [23:0] t, input logic [2:0] ix, input logic [31:0] base);
    in_tag   = t;
    in_index = ix;
    in_data  = make_line(base);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid    = 1'b0;
    mem_awready = 1'b1;
    mem_wready  = 1'b1;
    mem_bvalid  = 1'b1;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, want 0", busy, n);
    end
    mem_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = make_line(32'hDEAD_0000);
    #3;
    tests++;
    if ({in_ready, busy, mem_awvalid, mem_wvalid, mem_bready, mem_wlast} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {in_ready, busy, mem_awvalid, mem_wvalid, mem_bready, mem_wlast});
    end
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_capture: busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int cyc;
    mem_awready = 1'b1;
    mem_wready  = 1'b1;
    mem_bvalid  = 1'b1;
    offer(24'hABCDEF, 3'd5, 32'h1000_0000);
    cyc = 1;
    tests++;
    if (mem_awvalid !== 1'b1 || mem_awaddr !== 32'hABCDEFA0 || mem_awlen !== 8'd7) begin
      fails++;
      $display("FAIL basic_aw: awvalid=%b addr=%h len=%0d, want 1 abcdefa0 7",
               mem_awvalid, mem_awaddr, mem_awlen);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cyc++;
      tests++;
      if (mem_wvalid !== 1'b1 || mem_wdata !== 32'h1000_0000 + 32'(k) ||
          mem_wlast !== (k == 7)) begin
        fails++;
        $display("FAIL basic_beat%0d: wvalid=%b data=%h last=%b, want 1 %h %b", k, mem_wvalid,
                 mem_wdata, mem_wlast, 32'h1000_0000 + 32'(k), (k == 7));
      end
    end
    @(negedge clk);
    cyc++;
    tests++;
    if (mem_bready !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_b: bready=%b in_ready=%b, want 1 0", mem_bready, in_ready);
    end
    @(negedge clk);
    cyc++;
    tests++;
    if (in_ready !== 1'b1 || cyc != 11) begin
      fails++;
      $display("FAIL basic_occupancy: in_ready=%b at cycle %0d, want 1 at 11", in_ready, cyc);
    end
    mem_bvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    int   beats;
    int   c;
    logic stable;
    mem_awready = 1'b0;
    mem_wready  = 1'b0;
    mem_bvalid  = 1'b0;
    offer(24'h123456, 3'd2, 32'h2000_0000);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (mem_awvalid !== 1'b1 || mem_awaddr !== 32'h1234_5640) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL bp_aw_stall: awvalid=%b addr=%h, want 1 12345640", mem_awvalid, mem_awaddr);
    end
    mem_awready = 1'b1;
    beats  = 0;
    c      = 0;
    stable = 1'b1;
    while (!mem_bready && c < 40) begin
      @(negedge clk);
      c++;
      if (mem_wvalid) begin
        if (mem_wdata !== 32'h2000_0000 + 32'(beats) || mem_wlast !== (beats == 7))
          stable = 1'b0;
        mem_wready = (c % 2 == 1);
        if (mem_wready) beats++;
      end
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL bp_wdata: data=%h at beat %0d, want %h", mem_wdata, beats,
               32'h2000_0000 + 32'(beats));
    end
    tests++;
    if (beats != 8 || mem_bready !== 1'b1) begin
      fails++;
      $display("FAIL bp_beat_count: beats=%0d bready=%b, want 8 1", beats, mem_bready);
    end
    drain();
  endtask

  task automatic test_hold_second();
    int   c;
    logic saw_ready;
    logic first_ok;
    mem_awready = 1'b1;
    mem_wready  = 1'b1;
    mem_bvalid  = 1'b0;
    offer(24'h0F0F0F, 3'd1, 32'h3000_0000);
    in_tag    = 24'h777777;
    in_index  = 3'd6;
    in_data   = make_line(32'h4000_0000);
    in_valid  = 1'b1;
    saw_ready = 1'b0;
    first_ok  = 1'b0;
    c = 0;
    while (!mem_bready && c < 20) begin
      @(negedge clk);
      c++;
      if (in_ready) saw_ready = 1'b1;
      if (mem_wvalid && c == 1 && mem_wdata === 32'h3000_0000) first_ok = 1'b1;
    end
    tests++;
    if (saw_ready || !first_ok) begin
      fails++;
      $display("FAIL hold_busy: saw_ready=%b first_beat_ok=%b, want 0 1", saw_ready, first_ok);
    end
    repeat (2) @(negedge clk);
    mem_bvalid = 1'b1;
    @(negedge clk);
    mem_bvalid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || mem_awvalid !== 1'b0) begin
      fails++;
      $display("FAIL hold_no_bypass: in_ready=%b awvalid=%b, want 1 0", in_ready, mem_awvalid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (mem_awvalid !== 1'b1 || mem_awaddr !== 32'h7777_77C0) begin
      fails++;
      $display("FAIL hold_second_aw: awvalid=%b addr=%h, want 1 777777c0", mem_awvalid,
               mem_awaddr);
    end
    @(negedge clk);
    tests++;
    if (mem_wvalid !== 1'b1 || mem_wdata !== 32'h4000_0000) begin
      fails++;
      $display("FAIL hold_second_beat0: wvalid=%b data=%h, want 1 40000000", mem_wvalid,
               mem_wdata);
    end
    drain();
  endtask

  task automatic test_hazard();
    int c;
    mem_awready = 1'b1;
    mem_wready  = 1'b0;
    mem_bvalid  = 1'b0;
    offer(24'hC0FFEE, 3'd4, 32'h7000_0000);
    @(negedge clk);
    chk_tag   = 24'hC0FFEE;
    chk_index = 3'd4;
    #1;
    tests++;
    if (mem_wvalid !== 1'b1 || chk_hit !== 1'b1) begin
      fails++;
      $display("FAIL hazard_match: wvalid=%b chk_hit=%b, want 1 1", mem_wvalid, chk_hit);
    end
    chk_index = 3'd5;
    #1;
    tests++;
    if (chk_hit !== 1'b0) begin
      fails++;
      $display("FAIL hazard_index: chk_hit=%b, want 0", chk_hit);
    end
    chk_index = 3'd4;
    chk_tag   = 24'hC0FFEF;
    #1;
    tests++;
    if (chk_hit !== 1'b0) begin
      fails++;
      $display("FAIL hazard_tag: chk_hit=%b, want 0", chk_hit);
    end
    chk_tag    = 24'hC0FFEE;
    mem_wready = 1'b1;
    c = 0;
    while (!mem_bready && c < 20) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (mem_bready !== 1'b1 || chk_hit !== 1'b1) begin
      fails++;
      $display("FAIL hazard_in_b: bready=%b chk_hit=%b, want 1 1", mem_bready, chk_hit);
    end
    mem_bvalid = 1'b1;
    @(negedge clk);
    mem_bvalid = 1'b0;
    tests++;
    if (chk_hit !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hazard_clear: chk_hit=%b busy=%b, want 0 0", chk_hit, busy);
    end
    chk_tag   = '0;
    chk_index = '0;
  endtask

  task automatic test_async_reset();
    mem_awready = 1'b1;
    mem_wready  = 1'b1;
    mem_bvalid  = 1'b0;
    offer(24'h5A5A5A, 3'd3, 32'h5000_0000);
    repeat (5) @(negedge clk);
    tests++;
    if (mem_wdata !== 32'h5000_0004) begin
      fails++;
      $display("FAIL areset_setup: data=%h, want 50000004", mem_wdata);
    end
    chk_tag   = 24'h5A5A5A;
    chk_index = 3'd3;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, busy, mem_awvalid, mem_wvalid, mem_wlast, mem_bready, chk_hit} !== 7'b0 ||
        mem_awaddr !== 32'h0 || mem_awlen !== 8'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL areset_outputs: flags=%b addr=%h len=%h data=%h, want all 0",
               {in_ready, busy, mem_awvalid, mem_wvalid, mem_wlast, mem_bready, chk_hit},
               mem_awaddr, mem_awlen, mem_wdata);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || chk_hit !== 1'b0) begin
      fails++;
      $display("FAIL areset_release: in_ready=%b busy=%b chk_hit=%b, want 1 0 0", in_ready, busy,
               chk_hit);
    end
    chk_tag   = '0;
    chk_index = '0;
    offer(24'h010203, 3'd0, 32'h6000_0000);
    tests++;
    if (mem_awaddr !== 32'h0102_0300) begin
      fails++;
      $display("FAIL areset_new_aw: addr=%h, want 01020300", mem_awaddr);
    end
    @(negedge clk);
    tests++;
    if (mem_wvalid !== 1'b1 || mem_wdata !== 32'h6000_0000 || mem_wlast !== 1'b0) begin
      fails++;
      $display("FAIL areset_new_beat0: wvalid=%b data=%h last=%b, want 1 60000000 0", mem_wvalid,
               mem_wdata, mem_wlast);
    end
    drain();
  endtask

  task automatic test_spurious_b();
    mem_bvalid  = 1'b1;
    mem_awready = 1'b0;
    #1;
    tests++;
    if (mem_bready !== 1'b0) begin
      fails++;
      $display("FAIL spur_idle_bready: bready=%b, want 0", mem_bready);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL spur_idle_state: busy=%b in_ready=%b, want 0 1", busy, in_ready);
    end
    offer(24'h0BEEF0, 3'd7, 32'h8000_0000);
    repeat (2) @(negedge clk);
    tests++;
    if (mem_awvalid !== 1'b1 || mem_bready !== 1'b0 || mem_wvalid !== 1'b0) begin
      fails++;
      $display("FAIL spur_aw: awvalid=%b bready=%b wvalid=%b, want 1 0 0", mem_awvalid,
               mem_bready, mem_wvalid);
    end
    mem_bvalid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_hold_second();
    test_hazard();
    test_async_reset();
    test_spurious_b();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
